// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipe field.
//   state_t          - game state (IDLE, PLAY, OVER)
//   MATRIX_DIM       - LED matrix width/height
//   SHIFT_OFFSCREEN  - scroller position at which the pipe has left the matrix
//   LFSR_TAPS        - feedback tap mask for the gap LFSR (bits 7,5,4,3)
//   gap_from_lfsr    - maps an LFSR value onto a gap start row
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int MATRIX_DIM      = 16;
  localparam int SHIFT_OFFSCREEN = 16;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Low nibble of the LFSR, folded back so the whole gap fits on the matrix.
  function automatic logic [3:0] gap_from_lfsr(input logic [7:0] v, input int gap);
    logic [3:0] low;
    low = v[3:0];
    if (int'(low) <= MATRIX_DIM - gap) return low;
    else return low - 4'(gap);
  endfunction

endpackage

// File: rtl/gap_lfsr.sv
// gap_lfsr: 8-bit Fibonacci LFSR, shift left, feeding the pipe gap position.
//   clk  - system clock
//   rst  - asynchronous active-high reset, loads SEED
//   step - advance one position
//   lfsr - current register value
module gap_lfsr
  import pipe_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/pipe_field.sv
// pipe_field: consumes the scroller position, draws the pipe column, detects
// bird/pipe collisions, counts pipes cleared and freezes the scroller.
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   start      - one-cycle pulse, IDLE -> PLAY
//   shift      - scroller position, 0..15 on screen
//   bird_row   - bird row, 0 = top
//   gameover   - freeze request to the scroller (high in IDLE and OVER)
//   score      - pipes cleared, saturating at 255
//   pipe_col   - matrix column holding the pipe
//   pipe_valid - pipe is on screen
//   pipe_rows  - lit rows of pipe_col (1 = pipe, 0 = gap)
module pipe_field
  import pipe_pkg::*;
#(
  parameter int         BIRD_COL  = 3,
  parameter int         GAP       = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  int          shift,
  input  logic [3:0]  bird_row,
  output logic        gameover,
  output logic [7:0]  score,
  output logic [3:0]  pipe_col,
  output logic        pipe_valid,
  output logic [15:0] pipe_rows
);

  state_t      state_reg;
  int          prev_shift_reg;
  logic [7:0]  lfsr;
  logic [3:0]  gap_top;
  logic [15:0] gap_mask;
  logic        wrap;
  logic        shift_on;
  logic        collision;
  logic        pass;

  // The LFSR only advances when the scroller rolls over from off-screen to 0.
  assign wrap = (prev_shift_reg == SHIFT_OFFSCREEN) && (shift == 0);

  gap_lfsr #(
    .SEED (LFSR_SEED)
  ) u_gap_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (wrap),
    .lfsr (lfsr)
  );

  // Combinational from the LFSR register, so the new gap appears the cycle
  // after the wrap and reaches pipe_rows one edge later.
  assign gap_top = gap_from_lfsr(lfsr, GAP);

  genvar gi;
  generate
    for (gi = 0; gi < MATRIX_DIM; gi++) begin : g_mask
      assign gap_mask[gi] = !((gi >= int'(gap_top)) && (gi < int'(gap_top) + GAP));
    end
  endgenerate

  assign shift_on = (shift >= 0) && (shift < MATRIX_DIM);

  // Evaluated on the registered pipe image, hence two cycles shift->gameover.
  assign collision = (state_reg == PLAY) && pipe_valid &&
                     (pipe_col == 4'(BIRD_COL)) && pipe_rows[bird_row];

  // The pipe has just moved from the bird's column to the one behind it.
  assign pass = (state_reg == PLAY) && !collision &&
                (prev_shift_reg == MATRIX_DIM - 1 - BIRD_COL) &&
                (shift == MATRIX_DIM - BIRD_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gameover  <= 1'b1;
      score     <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= PLAY;
            gameover  <= 1'b0;
          end
        end
        PLAY: begin
          if (collision) begin
            state_reg <= OVER;
            gameover  <= 1'b1;
          end else if (pass && score != 8'hFF) begin
            score <= score + 8'd1;
          end
        end
        OVER: begin
          gameover <= 1'b1;
        end
        default: begin
          state_reg <= OVER;
          gameover  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_shift_reg <= SHIFT_OFFSCREEN;
      pipe_valid     <= 1'b0;
      pipe_col       <= 4'd0;
      pipe_rows      <= 16'd0;
    end else begin
      prev_shift_reg <= shift;
      if (shift_on) begin
        pipe_valid <= 1'b1;
        pipe_col   <= 4'(MATRIX_DIM - 1 - shift);
        pipe_rows  <= gap_mask;
      end else begin
        pipe_valid <= 1'b0;
        pipe_col   <= 4'd0;
        pipe_rows  <= 16'd0;
      end
    end
  end

endmodule

// File: doc/pipe_field.md
# pipe_field

Game-side consumer of the pipe scroll position. It takes `shift` from the pipe scroller and the bird's row, and drives the LED matrix's pipe column mask. It detects bird/pipe collisions, counts pipes cleared, and drives the `gameover` signal back to the scroller. A per-pipe gap position is drawn from an LFSR each time the scroller wraps.

## Interface
Parameters:
- `BIRD_COL`, 3: fixed matrix column of the bird (0..15).
- `GAP`, 4: number of open rows in each pipe.
- `LFSR_SEED`, 8'hA5: LFSR value after reset; must be nonzero.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle pulse; begins play from IDLE.
- `shift`  in  int (32)  scroll position from the pipe scroller, nominally 0..16.
- `bird_row`  in  4  current bird row, 0 = top.
- `gameover`  out  1  freeze request to the scroller.
- `score`  out  8  pipes cleared, saturating.
- `pipe_col`  out  4  matrix column currently holding the pipe.
- `pipe_valid`  out  1  pipe is on-screen.
- `pipe_rows`  out  16  lit rows of `pipe_col` (1 = pipe, 0 = gap).

## Operation
- **State machine** (`state_t`): IDLE, PLAY, OVER.
  - IDLE: `gameover`=1, which holds the scroller. `start` moves to PLAY.
  - PLAY: `gameover`=0. A collision moves to OVER.
  - OVER: `gameover`=1. Sticky until `rst`; `start` is ignored.
- **Pipe position:** for 0 ≤ `shift` ≤ 15, `pipe_valid`=1 and `pipe_col` = 15 − `shift`. For any other value, including 16, negative, or ≥17, `pipe_valid`=0 and `pipe_col`=0.
- **Gap:** `gap_top` (4 bits). Rows `gap_top`..`gap_top`+`GAP`−1 are 0 in `pipe_rows`; all other rows are 1. `pipe_rows`=0 when `pipe_valid`=0.
- **Gap generation:**
  - 8-bit Fibonacci LFSR, shift left, feedback bit = b7^b5^b4^b3.
  - `gap_top` = lfsr[3:0] if that value is ≤ 16−`GAP`, otherwise lfsr[3:0] − `GAP`.
  - The LFSR steps once per wrap. A wrap is `prev_shift`==16 and `shift`==0, where `prev_shift` is `shift` registered every cycle.
  - `gap_top` takes its new value on the cycle after the wrap is seen.
  - Wraps are processed in every state.
- **Collision** (PLAY only): `pipe_valid` and `pipe_col`==`BIRD_COL` and `pipe_rows[bird_row]`==1.
- **Score:**
  - A pass occurs when `prev_shift` == 15−`BIRD_COL` and `shift` == 16−`BIRD_COL`, in PLAY, with no collision in the same cycle.
  - Each pass increments `score` by 1. `score` saturates at 255.
  - A collision and a pass in the same cycle: the collision wins and the score is unchanged.
- **Scroller frozen:** `shift` holds, so no wrap or pass can fire. The state is unaffected.

## Timing
- **Reset values:** state=IDLE, `gameover`=1, `score`=0, lfsr=`LFSR_SEED`, `gap_top` from the seed (5 for 8'hA5), `prev_shift`=16, `pipe_valid`/`pipe_col`/`pipe_rows` registered from `shift` after release.
- **Registered outputs:** `pipe_col`, `pipe_valid`, and `pipe_rows` reflect the `shift` and `gap_top` sampled on the previous edge (1-cycle latency).
- **Collision latency:** collision is evaluated on the registered pipe outputs and the current `bird_row`. `gameover` rises on the edge after the condition is true, giving 2 cycles from `shift` to `gameover`.
- **Start:** `start` in IDLE causes `gameover` to fall on the next edge.
- **Pass:** the `score` increment is visible the cycle after the pass edge.
- **Reset mid-operation:** all registers return to reset values immediately (asynchronous). There is no pending-event carry-over.

## Structure
- **Package `pipe_pkg`:**
  - `state_t` enum (IDLE, PLAY, OVER).
  - `MATRIX_DIM`=16.
  - `SHIFT_OFFSCREEN`=16.
  - LFSR tap constant.
- **Sub-module `gap_lfsr`:** inputs clk, rst, step, seed parameter; output lfsr[7:0]. `pipe_field` derives `gap_top` from its output.
- **Top module:** FSM, `prev_shift`, pipe mask, collision logic, and score.

## Test plan
- **Reset:** assert `rst` with `shift`=0 → `gameover`=1, `score`=0, `gap_top`=5; the cycle after release `pipe_rows`=16'hFE1F, `pipe_col`=15.
- **Gap change on wrap:** drive `shift` 16 then 0 → lfsr becomes 8'h4A and `gap_top`=10. `pipe_rows`=16'hC3FF once the registered pipe outputs reflect it (wrap seen, then `gap_top` updates, then the outputs register).
- **Clean pass:** `start`, `bird_row`=6, `gap_top`=5, sweep `shift` 0→16 → no collision, `score`=1 the cycle after `shift` goes 12→13, and `gameover` stays 0.
- **Collision:** `start`, `bird_row`=0, `shift`=12 → `gameover`=1 two cycles later. Subsequent `start` pulses and passes leave `gameover`=1 and `score` unchanged.
- **Off-screen:** with `bird_row`=0 in PLAY, `shift`=16 or 20 → `pipe_valid`=0, `pipe_rows`=0, and no collision.
- **Saturation and async reset:** force 256 passes → `score` holds at 255. Asserting `rst` between clock edges clears `score` to 0 and `gameover` to 1 without waiting for a clock edge.
